// File: rtl/l1_inval_ctrl_if.sv
// Check-set port into the L1 valid array plus the L2 invalidate notification channel.
// evict_*: a notification transfers on a cycle where evict_valid && evict_ready; once raised, evict_valid and evict_index hold until that cycle.
interface l1_inval_ctrl_if #(
   parameter int IDX_W = 7
);
   logic [IDX_W-1:0] chk_read_index;
   logic             chk_check;
   logic             chk_clear;
   logic [IDX_W-1:0] chk_write_index;
   logic             refill_set;
   logic             evict_valid;
   logic [IDX_W-1:0] evict_index;
   logic             evict_ready;

   modport master (
      output chk_read_index, chk_clear, chk_write_index, evict_valid, evict_index,
      input  chk_check, refill_set, evict_ready
   );

   modport slave (
      input  chk_read_index, chk_clear, chk_write_index, evict_valid, evict_index,
      output chk_check, refill_set, evict_ready
   );
endinterface

// File: rtl/l1_inval_ctrl.sv
// L1 valid-array invalidation engine: sweeps the whole array (flush) or one line (inv),
// notifying L2 for each valid line before clearing it.
module l1_inval_ctrl #(
   parameter  int CHECK_LINE = 128,
   localparam int IDX_W      = $clog2(CHECK_LINE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req,
   input  logic             inv_req,
   input  logic [IDX_W-1:0] inv_index,
   output logic             busy,
   output logic             done,
   output logic [IDX_W:0]   flush_count,
   output logic [2:0]       dbg_state,
   l1_inval_ctrl_if.master  bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      NOTIFY = 3'd2,
      CLEAR  = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_LINE - 1);

   state_e           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic             single_q;
   logic [IDX_W:0]   cnt_q;
   logic [IDX_W:0]   flush_count_q;
   logic             busy_q;
   logic             done_q;
   logic             evict_valid_q;
   logic             chk_clear_q;
   logic             is_last;

   // A single invalidate always ends after its one line; a sweep ends at the top index, so ptr never wraps.
   assign is_last = single_q || (ptr_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         single_q      <= 1'b0;
         cnt_q         <= '0;
         flush_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         evict_valid_q <= 1'b0;
         chk_clear_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_req) begin
                  ptr_q    <= '0;
                  single_q <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= READ;
               end else if (inv_req) begin
                  ptr_q    <= inv_index;
                  single_q <= 1'b1;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= READ;
               end
            end
            READ: begin
               if (bus.chk_check) begin
                  evict_valid_q <= 1'b1;
                  state_q       <= NOTIFY;
               end else if (is_last) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            NOTIFY: begin
               if (bus.evict_ready) begin
                  evict_valid_q <= 1'b0;
                  chk_clear_q   <= 1'b1;
                  state_q       <= CLEAR;
               end
            end
            CLEAR: begin
               // The array lets a same-cycle refill set win over our clear, so retry until it lands.
               if (!bus.refill_set) begin
                  cnt_q       <= cnt_q + 1'b1;
                  chk_clear_q <= 1'b0;
                  if (is_last) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     ptr_q   <= ptr_q + 1'b1;
                     state_q <= READ;
                  end
               end
            end
            DONE: begin
               flush_count_q <= cnt_q;
               busy_q        <= 1'b0;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy                = busy_q;
   assign done                = done_q;
   assign flush_count         = flush_count_q;
   assign dbg_state           = state_q;
   assign bus.chk_read_index  = ptr_q;
   assign bus.chk_write_index = ptr_q;
   assign bus.evict_index     = ptr_q;
   assign bus.evict_valid     = evict_valid_q;
   assign bus.chk_clear       = chk_clear_q;
endmodule
